vga_scan_scheduler: RTL and testbench

- Sequences the VGA raster for the oscilloscope display: a horizontal pixel counter, a vertical line counter advanced once per line, registered sync/blank generation and pixel coordinates.
- Also arbitrates the shared sample-buffer RAM. The display path owns the RAM during the visible region. The acquisition path is granted it only inside vertical blanking, with a timeout revoke before the next visible frame.
- Sits between the 25 MHz clock domain root and the pixel renderer / acquisition writer.

---
 rtl/vga_scan_scheduler.sv | 127 ++++++++++++
 tb/tb_vga_scan_scheduler.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_scan_scheduler.sv
// VGA raster sequencer: h/v counters, registered sync/blank/pixel decode, and the
// sample-RAM arbiter that lends the RAM to acquisition only during vertical blanking.
module vga_scan_scheduler #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int SYNC_ACTIVE = 0
) (
    input  logic        clk_25MHz,
    input  logic        rst,
    input  logic        enable,
    output logic [15:0] h_count,
    output logic [15:0] v_count,
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic [9:0]  pixel_x,
    output logic [9:0]  pixel_y,
    output logic        line_end,
    output logic        frame_end,
    input  logic        acq_req,
    input  logic        acq_done,
    output logic        acq_grant,
    output logic        acq_abort
);

    localparam logic [15:0] H_LAST   = 16'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [15:0] V_LAST   = 16'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [15:0] H_VIS    = 16'(H_ACTIVE);
    localparam logic [15:0] V_VIS    = 16'(V_ACTIVE);
    localparam logic [15:0] HS_FIRST = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_LAST  = 16'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [15:0] VS_FIRST = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_LAST  = 16'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic        SYNC_ON  = (SYNC_ACTIVE != 0);

    typedef enum logic [1:0] {IDLE, WAIT_VB, GRANT, DONE} arb_state_t;

    arb_state_t state, state_nxt;
    logic       abort_nxt;
    logic       h_last, v_last, visible, in_hs, in_vs, grant_window;

    assign h_last       = (h_count == H_LAST);
    assign v_last       = (v_count == V_LAST);
    assign visible      = (h_count < H_VIS) && (v_count < V_VIS);
    assign in_hs        = (h_count >= HS_FIRST) && (h_count <= HS_LAST);
    assign in_vs        = (v_count >= VS_FIRST) && (v_count <= VS_LAST);
    // Last blank line is excluded so the grant is always gone before line 0 is drawn.
    assign grant_window = (v_count >= V_VIS) && (v_count < V_LAST);

    always_ff @(posedge clk_25MHz) begin
        if (rst || !enable) begin
            h_count <= '0;
            v_count <= '0;
        end else if (h_last) begin
            h_count <= '0;
            v_count <= v_last ? 16'd0 : v_count + 16'd1;
        end else begin
            h_count <= h_count + 16'd1;
        end
    end

    always_ff @(posedge clk_25MHz) begin
        if (rst || !enable) begin
            hsync     <= !SYNC_ON;
            vsync     <= !SYNC_ON;
            video_on  <= 1'b0;
            pixel_x   <= '0;
            pixel_y   <= '0;
            line_end  <= 1'b0;
            frame_end <= 1'b0;
        end else begin
            hsync     <= in_hs ? SYNC_ON : !SYNC_ON;
            vsync     <= in_vs ? SYNC_ON : !SYNC_ON;
            video_on  <= visible;
            pixel_x   <= visible ? h_count[9:0] : 10'd0;
            pixel_y   <= visible ? v_count[9:0] : 10'd0;
            line_end  <= h_last;
            frame_end <= h_last && v_last;
        end
    end

    always_ff @(posedge clk_25MHz) begin
        if (rst) begin
            state     <= IDLE;
            acq_abort <= 1'b0;
        end else begin
            state     <= state_nxt;
            acq_abort <= abort_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        abort_nxt = 1'b0;
        if (!enable) begin
            state_nxt = IDLE;
            abort_nxt = (state == GRANT);
        end else begin
            case (state)
                IDLE:    if (acq_req) state_nxt = WAIT_VB;
                WAIT_VB: begin
                    if (!acq_req)          state_nxt = IDLE;
                    else if (grant_window) state_nxt = GRANT;
                end
                GRANT: begin
                    if (acq_done) begin
                        state_nxt = DONE;
                    end else if (v_last && h_count == 16'd0) begin
                        state_nxt = DONE;
                        abort_nxt = 1'b1;
                    end
                end
                DONE:    if (h_last && v_last) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign acq_grant = (state == GRANT);

endmodule

// File: tb/tb_vga_scan_scheduler.sv
// Directed bench for vga_scan_scheduler on a shrunken raster (25x19) so whole
// frames fit in a short run; expected values come from the timing constants below.
module tb_vga_scan_scheduler;

    localparam int HA = 16, HF = 2, HS = 4, HB = 3, HT = HA + HF + HS + HB;  // 25
    localparam int VA = 12, VF = 2, VS = 2, VB = 3, VT = VA + VF + VS + VB;  // 19

    logic        clk_25MHz = 1'b0;
    logic        rst, enable, acq_req, acq_done;
    logic [15:0] h_count, v_count;
    logic        hsync, vsync, video_on, line_end, frame_end, acq_grant, acq_abort;
    logic [9:0]  pixel_x, pixel_y;

    int errors = 0, checks = 0;
    int ncyc, n_vid, n_hs, n_vs, n_le, n_fe, last_le, last_fe, fe_gap, bad_gap;
    int bad_pix, bad_gv, n_gr, n_ab, hs_h, vs_h, vs_v, lpx, lpy, k;

    vga_scan_scheduler #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_ACTIVE(0)
    ) dut (
        .clk_25MHz(clk_25MHz), .rst(rst), .enable(enable),
        .h_count(h_count), .v_count(v_count), .hsync(hsync), .vsync(vsync),
        .video_on(video_on), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .line_end(line_end), .frame_end(frame_end),
        .acq_req(acq_req), .acq_done(acq_done),
        .acq_grant(acq_grant), .acq_abort(acq_abort)
    );

    always #20 clk_25MHz = ~clk_25MHz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_stats();
        ncyc = 0; n_vid = 0; n_hs = 0; n_vs = 0; n_le = 0; n_fe = 0;
        last_le = -1; last_fe = -1; fe_gap = 0; bad_gap = 0; bad_pix = 0; bad_gv = 0;
        n_gr = 0; n_ab = 0; hs_h = -1; vs_h = -1; vs_v = -1; lpx = -1; lpy = -1;
    endtask

    // One clock, then sample 1 ns past the edge and accumulate raster statistics.
    task automatic cyc();
        @(posedge clk_25MHz);
        #1;
        ncyc++;
        if (video_on) n_vid++;
        if (!hsync) begin n_hs++; if (hs_h < 0) hs_h = int'(h_count); end
        if (!vsync) begin
            n_vs++;
            if (vs_v < 0) begin vs_h = int'(h_count); vs_v = int'(v_count); end
        end
        if (line_end) begin
            n_le++;
            if (last_le >= 0 && ncyc - last_le != HT) bad_gap++;
            last_le = ncyc;
        end
        if (frame_end) begin
            n_fe++;
            if (last_fe >= 0) fe_gap = ncyc - last_fe;
            last_fe = ncyc;
        end
        if (!video_on && (pixel_x != 0 || pixel_y != 0)) bad_pix++;
        if (acq_grant && video_on) bad_gv++;
        if (acq_grant) n_gr++;
        if (acq_abort) n_ab++;
        if (h_count == 16'(HA) && v_count == 16'(VA - 1)) begin
            lpx = int'(pixel_x); lpy = int'(pixel_y);
        end
    endtask

    task automatic run_to(input int h, input int v);
        int n;
        n = 0;
        while (!(h_count == 16'(h) && v_count == 16'(v)) && n < 2000) begin
            cyc(); n++;
        end
        chk("run_to_reached", (h_count == 16'(h) && v_count == 16'(v)), 1);
    endtask

    initial begin
        rst = 1'b1; enable = 1'b0; acq_req = 1'b0; acq_done = 1'b0;
        clear_stats();
        repeat (3) cyc();
        chk("rst_h", h_count, 0);
        chk("rst_v", v_count, 0);
        chk("rst_hsync", hsync, 1);
        chk("rst_vsync", vsync, 1);
        chk("rst_video", video_on, 0);
        chk("rst_line_end", line_end, 0);
        chk("rst_grant", acq_grant, 0);
        chk("rst_abort", acq_abort, 0);

        // Two full frames of raster
        rst = 1'b0; enable = 1'b1;
        clear_stats();
        repeat (2 * HT * VT) cyc();
        chk("frames_end_h", h_count, 0);
        chk("frames_end_v", v_count, 0);
        chk("line_end_count", n_le, 2 * VT);
        chk("line_end_gap_bad", bad_gap, 0);
        chk("frame_end_count", n_fe, 2);
        chk("frame_end_gap", fe_gap, HT * VT);
        chk("video_on_count", n_vid, 2 * HA * VA);
        chk("hsync_low_count", n_hs, 2 * HS * VT);
        chk("vsync_low_count", n_vs, 2 * VS * HT);
        chk("hsync_first_low_h", hs_h, HA + HF + 1);
        chk("vsync_first_low_v", vs_v, VA + VF);
        chk("vsync_first_low_h", vs_h, 1);
        chk("last_pixel_x", lpx, HA - 1);
        chk("last_pixel_y", lpy, VA - 1);
        chk("pixel_nonzero_blank", bad_pix, 0);

        // Grant in blanking, released by acq_done
        run_to(0, 5);
        acq_req = 1'b1;
        for (int i = 0; i < 1000 && !acq_grant; i++) cyc();
        chk("grant1_rise", acq_grant, 1);
        chk("grant1_h", h_count, 1);
        chk("grant1_v", v_count, VA);
        run_to(0, VA + VF);
        acq_done = 1'b1;
        cyc();
        acq_done = 1'b0;
        chk("done_grant_drop", acq_grant, 0);
        chk("done_no_abort", acq_abort, 0);
        clear_stats();
        run_to(0, 0);
        chk("one_grant_per_frame", n_gr, 0);
        chk("done_no_abort_later", n_ab, 0);

        // Next frame: grant again, no acq_done -> timeout revoke
        clear_stats();
        for (int i = 0; i < 1000 && !acq_grant; i++) cyc();
        chk("grant2_h", h_count, 1);
        chk("grant2_v", v_count, VA);
        for (int i = 0; i < 1000 && !acq_abort; i++) cyc();
        chk("timeout_abort", acq_abort, 1);
        chk("timeout_abort_v", v_count, VT - 1);
        chk("timeout_abort_h", h_count, 1);
        chk("timeout_grant_drop", acq_grant, 0);
        acq_req = 1'b0;
        cyc();
        chk("abort_one_cycle", acq_abort, 0);
        chk("abort_count", n_ab, 1);

        // acq_done on the timeout cycle: done wins
        run_to(0, 5);
        acq_req = 1'b1;
        run_to(0, VT - 1);
        chk("coinc_grant_before", acq_grant, 1);
        acq_done = 1'b1;
        cyc();
        acq_done = 1'b0;
        acq_req = 1'b0;
        chk("coinc_grant_drop", acq_grant, 0);
        chk("coinc_no_abort", acq_abort, 0);
        cyc();
        chk("coinc_no_abort_late", acq_abort, 0);

        // enable dropped mid-grant
        run_to(0, 5);
        acq_req = 1'b1;
        run_to(5, VA + VF + 1);
        chk("en_grant_before", acq_grant, 1);
        enable = 1'b0;
        cyc();
        chk("en_abort", acq_abort, 1);
        chk("en_grant_drop", acq_grant, 0);
        chk("en_h_zero", h_count, 0);
        chk("en_v_zero", v_count, 0);
        chk("en_hsync_idle", hsync, 1);
        chk("en_vsync_idle", vsync, 1);
        chk("en_video_off", video_on, 0);
        acq_req = 1'b0;
        repeat (3) cyc();
        chk("en_abort_pulse", acq_abort, 0);
        chk("en_h_held", h_count, 0);
        enable = 1'b1;
        k = 0;
        do begin cyc(); k++; end while (!line_end && k < 1000);
        chk("reenable_line_end_cycles", k, HT);

        // Reset mid-grant: no abort
        acq_req = 1'b1;
        run_to(3, VA + 1);
        chk("rst_grant_before", acq_grant, 1);
        rst = 1'b1;
        cyc();
        chk("rst2_h", h_count, 0);
        chk("rst2_v", v_count, 0);
        chk("rst2_grant", acq_grant, 0);
        chk("rst2_abort", acq_abort, 0);
        chk("rst2_hsync", hsync, 1);
        chk("rst2_pixel_x", pixel_x, 0);
        rst = 1'b0; acq_req = 1'b0;
        chk("grant_during_video", bad_gv, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
